// File: rtl/booth_pkg.sv
// booth_pkg: shared widths and booth_bits encodings for the Booth multiplier datapath.
package booth_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;
    localparam int PW = 2 * DEF_WIDTH;
    typedef enum logic [1:0] {
        BB_NOP0 = 2'b00,
        BB_ADD  = 2'b01,
        BB_SUB  = 2'b10,
        BB_NOP1 = 2'b11
    } booth_bits_e;
endpackage

// File: rtl/booth_datapath_if.sv
// booth_datapath_if: FSM <-> datapath bundle; master is the control FSM, slave the datapath.
// BOOTH_OPCNT_EN adds the op_count debug output.
interface booth_datapath_if import booth_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic load;
    logic add_en;
    logic sub_en;
    logic shift_en;
    logic count_en;
    logic booth_done;
    logic [1:0] booth_bits;
    logic done;
    logic [2*WIDTH-1:0] product;
    logic product_valid;
`ifdef BOOTH_OPCNT_EN
    logic [CNT_W-1:0] op_count;
`endif
    modport master (
        output multiplicand, multiplier, load, add_en, sub_en, shift_en, count_en, booth_done,
        input booth_bits, done, product, product_valid
`ifdef BOOTH_OPCNT_EN
        , input op_count
`endif
    );
    modport slave (
        input multiplicand, multiplier, load, add_en, sub_en, shift_en, count_en, booth_done,
        output booth_bits, done, product, product_valid
`ifdef BOOTH_OPCNT_EN
        , output op_count
`endif
    );
endinterface

// File: rtl/booth_counter.sv
// booth_counter: wrapping counter with sync active-low reset, clear and enable.
module booth_counter import booth_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset || clear) count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/booth_datapath.sv
// booth_datapath: A/Q/Q-1/M registers and iteration counter of the radix-2 Booth multiplier.
// Define BOOTH_OPCNT_EN to count add/sub steps on op_count.
module booth_datapath import booth_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic reset,
    booth_datapath_if.slave bus
);
    logic [WIDTH-1:0] a, q, m;
    logic q_1;
    logic valid;
    logic [CNT_W-1:0] count;
    // load wins over sub, sub over add, add over shift when the FSM overlaps them
    always_ff @(posedge clk) begin
        if (!reset) begin
            a <= '0;
            q <= '0;
            q_1 <= 1'b0;
            m <= '0;
            valid <= 1'b0;
        end else begin
            valid <= bus.booth_done;
            if (bus.load) begin
                a <= '0;
                q <= bus.multiplier;
                q_1 <= 1'b0;
                m <= bus.multiplicand;
            end else if (bus.sub_en) a <= a - m;
            else if (bus.add_en) a <= a + m;
            else if (bus.shift_en) {a, q, q_1} <= {a[WIDTH-1], a, q};
        end
    end
    booth_counter #(.CNT_W(CNT_W)) u_iter (
        .clk(clk), .reset(reset), .clear(bus.load), .en(bus.count_en), .count(count)
    );
`ifdef BOOTH_OPCNT_EN
    booth_counter #(.CNT_W(CNT_W)) u_ops (
        .clk(clk), .reset(reset), .clear(bus.load), .en(bus.add_en | bus.sub_en),
        .count(bus.op_count)
    );
`endif
    assign bus.booth_bits = {q[0], q_1};
    assign bus.done = count == CNT_W'(WIDTH - 1);
    assign bus.product = {a, q};
    assign bus.product_valid = valid;
endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath: directed checks of the Booth datapath with the FSM emulated in tasks.
module tb_booth_datapath;
    import booth_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    booth_datapath_if #(.WIDTH(8), .CNT_W(4)) bus ();
    booth_datapath #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ld, sb, ad, sh, ce, bd);
        bus.load = ld; bus.sub_en = sb; bus.add_en = ad;
        bus.shift_en = sh; bus.count_en = ce; bus.booth_done = bd;
        cyc();
        bus.load = 0; bus.sub_en = 0; bus.add_en = 0;
        bus.shift_en = 0; bus.count_en = 0; bus.booth_done = 0;
    endtask

    task automatic load_op(input logic [7:0] mc, input logic [7:0] mp);
        bus.multiplicand = mc;
        bus.multiplier = mp;
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic run(input string tag, input logic [7:0] mc, input logic [7:0] mp);
        load_op(mc, mp);
        for (int i = 0; i < 8; i++) begin
            if (bus.booth_bits == BB_ADD) step(0, 0, 1, 0, 0, 0);
            else if (bus.booth_bits == BB_SUB) step(0, 1, 0, 0, 0, 0);
            chk($sformatf("%s_done%0d", tag, i), {31'd0, bus.done}, {31'd0, i == 7});
            step(0, 0, 0, 1, 1, 0);
        end
        chk({tag, "_valid_pre"}, {31'd0, bus.product_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk({tag, "_valid_pulse"}, {31'd0, bus.product_valid}, 32'd1);
        cyc();
        chk({tag, "_valid_post"}, {31'd0, bus.product_valid}, 32'd0);
    endtask

    initial begin
        bus.multiplicand = '0; bus.multiplier = '0;
        bus.load = 0; bus.sub_en = 0; bus.add_en = 0;
        bus.shift_en = 0; bus.count_en = 0; bus.booth_done = 0;
        cyc();
        cyc();
        chk("rst_product", {16'd0, bus.product}, 32'h0);
        chk("rst_bits", {30'd0, bus.booth_bits}, 32'h0);
        chk("rst_done", {31'd0, bus.done}, 32'h0);
        chk("rst_valid", {31'd0, bus.product_valid}, 32'h0);
        reset = 1'b1;

        // 5 x 3 interrupted by reset after a sub and a shift
        load_op(8'd5, 8'd3);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("midop_product", {16'd0, bus.product}, 32'hFD81);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("midrst_product", {16'd0, bus.product}, 32'h0);
        chk("midrst_bits", {30'd0, bus.booth_bits}, 32'h0);
        chk("midrst_done", {31'd0, bus.done}, 32'h0);
        chk("midrst_valid", {31'd0, bus.product_valid}, 32'h0);
        step(0, 0, 1, 0, 0, 0);
        chk("midrst_m_zero", {16'd0, bus.product}, 32'h0);
        run("m5x3", 8'd5, 8'd3);
        chk("m5x3_product", {16'd0, bus.product}, 32'h000F);
`ifdef BOOTH_OPCNT_EN
        chk("m5x3_opcnt", {28'd0, bus.op_count}, 32'd2);
`endif

        run("m3xn2", 8'h03, 8'hFE);
        chk("m3xn2_product", {16'd0, bus.product}, 32'hFFFA);
`ifdef BOOTH_OPCNT_EN
        chk("m3xn2_opcnt", {28'd0, bus.op_count}, 32'd1);
`endif
        step(0, 0, 0, 0, 0, 0);
        chk("hold_product", {16'd0, bus.product}, 32'hFFFA);

        run("m127", 8'h7F, 8'h7F);
        chk("m127_product", {16'd0, bus.product}, 32'h3F01);
`ifdef BOOTH_OPCNT_EN
        chk("m127_opcnt", {28'd0, bus.op_count}, 32'd2);
`endif

        run("m55x0", 8'h55, 8'h00);
        chk("m55x0_product", {16'd0, bus.product}, 32'h0);
`ifdef BOOTH_OPCNT_EN
        chk("m55x0_opcnt", {28'd0, bus.op_count}, 32'd0);
`endif

        // M = -128: the sub wraps A modulo 2^8 and the shift replicates the wrapped MSB
        load_op(8'h80, 8'h80);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0);
        chk("m128_bits", {30'd0, bus.booth_bits}, 32'h2);
        chk("m128_pre_sub", {16'd0, bus.product}, 32'h0001);
        step(0, 1, 0, 0, 0, 0);
        chk("m128_sub_wrap", {16'd0, bus.product}, 32'h8001);
        step(0, 0, 0, 1, 1, 0);
        chk("m128_shift", {16'd0, bus.product}, 32'hC000);
        chk("m128_done", {31'd0, bus.done}, 32'h0);

        load_op(8'h00, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1, 1, 0);
            if (k >= 6) chk($sformatf("done_after_%0d", k), {31'd0, bus.done}, {31'd0, k == 7});
        end

        bus.multiplicand = 8'd5;
        bus.multiplier = 8'd3;
        step(1, 0, 1, 0, 0, 0);
        chk("ovl_load_add", {16'd0, bus.product}, 32'h0003);
        step(0, 1, 1, 0, 0, 0);
        chk("ovl_sub_add", {16'd0, bus.product}, 32'hFB03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
